morse_key_decoder: RTL and testbench
====================================

Name: morse_key_decoder

Overview:
- Receive-side counterpart to the board's timed-pattern LED blinker.
- Samples a raw push-button (Morse key) input, then debounces it.
- Times each press and each gap in dot units; classifies each press as dot or dash.
- Emits one decoded symbol per letter, plus a word-gap strobe, to downstream logic on the TinyFPGA BX fabric (16 MHz CLK).

Parameters:
- UNIT_CYCLES, 2097152, CLK cycles per Morse time unit (~131 ms at 16 MHz).
- DEBOUNCE_CYCLES, 16000, consecutive stable cycles required to accept a level change (1 ms).
- MAX_ELEMS, 5, maximum dots/dashes per symbol; must be ≤ 15.

Ports:
- CLK  input  1  system clock, 16 MHz.
- RST  input  1  reset, asynchronous, active-high.
- KEY  input  1  raw, asynchronous key level; 1 = pressed.
- LED  output  1  echo of the debounced key level.
- SYM_VALID  output  1  one-cycle strobe: symbol complete.
- SYM_CODE  output  MAX_ELEMS  element bits; 0 = dot, 1 = dash; first element in bit 0; unused bits 0.
- SYM_LEN  output  4  number of elements in SYM_CODE.
- SYM_ERR  output  1  symbol had overflow or an over-long mark; valid with SYM_VALID.
- WORD_GAP  output  1  one-cycle strobe: word gap detected.

Behaviour:
- Reset (async assert, sync release): synchronizer flops, debounced level, counters, code/len/err cleared; FSM = IDLE.
  - All outputs 0 during and after reset.
  - Reset mid-symbol discards the partial symbol; no strobe is emitted.
- Input path: KEY passes through a 2-flop synchronizer, then the debouncer.
  - Debounce counter resets whenever the synced level equals the debounced level.
  - Debounced level flips only after DEBOUNCE_CYCLES consecutive cycles at the opposite level.
  - LED = debounced level.
- Edge: one-cycle rise/fall pulse on each debounced-level change. All timing is measured from debounced edges, so debounce latency cancels out.
- Timer:
  - Prescaler counts 0..UNIT_CYCLES-1; unit counter (3 bits) increments on each wrap and saturates at 7.
  - Both counters clear on every debounced edge.
  - If an edge and a prescaler wrap occur in the same cycle, the edge wins: classification uses the pre-increment unit count, then counters clear.
- FSM states: IDLE, MARK, SPACE, GAP.
  - IDLE: on rise → MARK; code/len/err already 0.
  - MARK, on fall:
    - element = (units ≥ 2) ? dash : dot.
    - If len < MAX_ELEMS: write the element at bit len, len += 1.
    - Else: err = 1; code and len unchanged.
    - → SPACE.
  - MARK, unit count reaching 7 while pressed: err = 1 (over-long mark); the element is still a dash on release.
  - SPACE, on rise → MARK (inter-element gap).
  - SPACE, unit count reaching 3 with no rise:
    - Pulse SYM_VALID for 1 cycle, with SYM_CODE/SYM_LEN/SYM_ERR valid in that same cycle.
    - Next cycle: clear code/len/err → GAP.
  - GAP, on rise → MARK (new letter, no word gap).
  - GAP, unit count reaching 7 → pulse WORD_GAP for 1 cycle → IDLE.
- Symbol latency: SYM_VALID asserts exactly 3*UNIT_CYCLES cycles after the final debounced fall.
- Word-gap latency: WORD_GAP asserts exactly 7*UNIT_CYCLES cycles after the final debounced fall.
- Symbol fields:
  - SYM_CODE/SYM_LEN/SYM_ERR are registered and hold their values between strobes; they are only guaranteed while SYM_VALID = 1.
  - SYM_VALID and WORD_GAP are never high in the same cycle.
- A held key never produces a strobe until it is released.

Test Plan (UNIT_CYCLES=16, DEBOUNCE_CYCLES=4):
- Reset: hold RST 5 cycles with KEY toggling → all outputs 0. Release with KEY=0, run 200 cycles → no strobes.
- Letter 'A': KEY high 20 cycles, low 20, high 40, then low → one SYM_VALID with CODE=5'b00010, LEN=2, ERR=0, exactly 48 cycles after the debounced fall.
- Glitch rejection: 1–3-cycle KEY pulses separated by 5 low cycles → LED stays 0; no SYM_VALID and no WORD_GAP ever.
- Overflow: six 10-cycle presses with 20-cycle gaps → single SYM_VALID with CODE=0, LEN=5, ERR=1.
- Word gap:
  - 'E' (one 10-cycle press), then idle → SYM_VALID at +48 and WORD_GAP at +112 cycles after the debounced fall.
  - Repeat with a new press at +80 → no WORD_GAP.
- Reset mid-MARK: press, assert RST after 10 cycles, release → no strobe. A clean 'E' afterwards → CODE=0, LEN=1, ERR=0.

Source files
------------

// File: rtl/morse_key_decoder.sv
// Purpose: decode a debounced Morse key into per-letter dot/dash codes and word-gap strobes.
// Latency: SYM_VALID 3 units, WORD_GAP 7 units after the final debounced release; key path 2 + DEBOUNCE_CYCLES.
// Backpressure: none; SYM_VALID/WORD_GAP are single-cycle strobes the consumer must capture when they fire.
//
// Ports:
//   CLK        system clock (16 MHz on the TinyFPGA BX)
//   RST        asynchronous, active-high reset
//   KEY        raw asynchronous key level, 1 = pressed
//   LED        debounced key level
//   SYM_VALID  one-cycle strobe, symbol complete; SYM_CODE/SYM_LEN/SYM_ERR valid in the same cycle
//   SYM_CODE   element bits, 0 = dot, 1 = dash, first element in bit 0, unused bits 0
//   SYM_LEN    number of elements in SYM_CODE
//   SYM_ERR    symbol overflowed MAX_ELEMS or contained an over-long mark
//   WORD_GAP   one-cycle strobe, word gap detected
//
// MAX_ELEMS must be 15 or less so the element count fits in SYM_LEN.
module morse_key_decoder #(
    parameter int UNIT_CYCLES     = 2097152,
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int MAX_ELEMS       = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 KEY,
    output logic                 LED,
    output logic                 SYM_VALID,
    output logic [MAX_ELEMS-1:0] SYM_CODE,
    output logic [3:0]           SYM_LEN,
    output logic                 SYM_ERR,
    output logic                 WORD_GAP
);

    localparam int PW = $clog2(UNIT_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    LEN_MAX    = 4'(MAX_ELEMS);

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous key level.
    // ------------------------------------------------------------------
    logic key_meta;
    logic key_sync;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer: the accepted level flips only after DEBOUNCE_CYCLES
    // consecutive synced samples at the opposite level. Any sample that
    // agrees with the accepted level restarts the count.
    // ------------------------------------------------------------------
    logic          db_level;
    logic          db_prev;
    logic [DW-1:0] db_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            db_prev <= db_level;
            if (key_sync == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= key_sync;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Edge pulses are one cycle wide, in the first cycle of the new level.
    // Both press and release see the same debounce delay, so durations
    // measured between these pulses equal the key's true durations.
    logic rise;
    logic fall;
    logic any_edge;

    assign rise     = db_level & ~db_prev;
    assign fall     = ~db_level & db_prev;
    assign any_edge = rise | fall;

    // ------------------------------------------------------------------
    // Unit timer: prescaler divides CLK down to Morse units; the unit
    // counter saturates at 7, which is the longest interval that matters.
    // An edge takes priority over a simultaneous wrap, so the FSM always
    // classifies with the count as it stood before the wrap.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic [2:0]    units;
    logic          unit_wrap;
    logic          units_to_3;
    logic          units_to_7;

    assign unit_wrap  = (presc == PRESC_LAST);
    assign units_to_3 = unit_wrap && (units == 3'd2);
    assign units_to_7 = unit_wrap && (units == 3'd6);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
            units <= '0;
        end else if (any_edge) begin
            presc <= '0;
            units <= '0;
        end else if (unit_wrap) begin
            presc <= '0;
            if (units != 3'd7) begin
                units <= units + 3'd1;
            end
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Symbol FSM.
    //   IDLE  : nothing in progress, code/len/err are zero
    //   MARK  : key held, timing the element
    //   SPACE : key released inside a letter
    //   GAP   : letter emitted, waiting to see if the silence becomes a word gap
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [MAX_ELEMS-1:0] code;
    logic [MAX_ELEMS-1:0] code_nxt;
    logic [3:0]           len;
    logic [3:0]           len_nxt;
    logic                 err;
    logic                 err_nxt;
    logic                 sym_vld_c;
    logic                 word_gap_c;
    logic                 elem_dash;

    // Two or more whole units held before release makes a dash.
    assign elem_dash = (units >= 3'd2);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            code  <= '0;
            len   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            code  <= code_nxt;
            len   <= len_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        code_nxt   = code;
        len_nxt    = len;
        err_nxt    = err;
        sym_vld_c  = 1'b0;
        word_gap_c = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MARK;
                end
            end

            MARK: begin
                if (fall) begin
                    if (len < LEN_MAX) begin
                        // Element lands at bit position len.
                        for (int i = 0; i < MAX_ELEMS; i++) begin
                            if (len == 4'(i)) begin
                                code_nxt[i] = elem_dash;
                            end
                        end
                        len_nxt = len + 4'd1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = SPACE;
                end else if (units_to_7) begin
                    // Over-long mark: flag it now, still recorded as a dash on release.
                    err_nxt = 1'b1;
                end
            end

            SPACE: begin
                if (rise) begin
                    state_nxt = MARK;
                end else if (units_to_3) begin
                    // Registered fields are presented during this strobe and
                    // cleared on the way into GAP.
                    sym_vld_c = 1'b1;
                    code_nxt  = '0;
                    len_nxt   = '0;
                    err_nxt   = 1'b0;
                    state_nxt = GAP;
                end
            end

            GAP: begin
                if (rise) begin
                    state_nxt = MARK;
                end else if (units_to_7) begin
                    // Units keep counting from the last release through SPACE,
                    // so this fires 7 units after that release.
                    word_gap_c = 1'b1;
                    state_nxt  = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign LED       = db_level;
    assign SYM_VALID = sym_vld_c;
    assign SYM_CODE  = code;
    assign SYM_LEN   = len;
    assign SYM_ERR   = err;
    assign WORD_GAP  = word_gap_c;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Purpose: self-checking bench for morse_key_decoder, directed cases plus randomized key sequences.
// Latency: strobe timing is measured against the observed debounced release.
// Backpressure: none; every strobe is logged by a monitor and matched against a duration-based model.
module tb_morse_key_decoder;

    localparam int U  = 16;
    localparam int D  = 4;
    localparam int ME = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic          KEY;
    logic          LED;
    logic          SYM_VALID;
    logic [ME-1:0] SYM_CODE;
    logic [3:0]    SYM_LEN;
    logic          SYM_ERR;
    logic          WORD_GAP;

    always #5 CLK = ~CLK;

    morse_key_decoder #(
        .UNIT_CYCLES     (U),
        .DEBOUNCE_CYCLES (D),
        .MAX_ELEMS       (ME)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .KEY       (KEY),
        .LED       (LED),
        .SYM_VALID (SYM_VALID),
        .SYM_CODE  (SYM_CODE),
        .SYM_LEN   (SYM_LEN),
        .SYM_ERR   (SYM_ERR),
        .WORD_GAP  (WORD_GAP)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // ------------------------------------------------------------------
    // Monitor: logs strobes and debounced release cycles.
    // ------------------------------------------------------------------
    typedef struct {
        int cyc;
        int code;
        int len;
        int err;
    } obs_t;

    obs_t sym_q[$];
    int   wg_q[$];
    int   fall_q[$];
    int   led_rises = 0;
    logic led_d     = 1'b0;
    obs_t mon_o;

    always @(negedge CLK) begin
        if (RST) begin
            led_d = 1'b0;
        end else begin
            if (led_d && !LED) fall_q.push_back(cyc);
            if (!led_d && LED) led_rises++;
            led_d = LED;
            if (SYM_VALID) begin
                mon_o.cyc  = cyc;
                mon_o.code = int'(SYM_CODE);
                mon_o.len  = int'(SYM_LEN);
                mon_o.err  = int'(SYM_ERR);
                sym_q.push_back(mon_o);
            end
            if (WORD_GAP) wg_q.push_back(cyc);
            if (SYM_VALID || WORD_GAP) chk("strobe_exclusive", int'(SYM_VALID && WORD_GAP), 0);
        end
    end

    // ------------------------------------------------------------------
    // Reference model: works purely on mark/gap durations in cycles.
    // Mark > 2U is a dash, mark > 7U is an error, gap > 3U ends a letter,
    // gap > 7U also ends a word.
    // ------------------------------------------------------------------
    typedef struct {
        int code;
        int len;
        int err;
        int idx;
    } exp_t;

    int   mark_q[$];
    int   gap_q[$];
    exp_t exp_sym[$];
    int   exp_wg[$];

    task automatic build_model();
        int   code = 0;
        int   len  = 0;
        int   err  = 0;
        exp_t e;
        exp_sym.delete();
        exp_wg.delete();
        foreach (mark_q[i]) begin
            if (len < ME) begin
                if (mark_q[i] > 2 * U) code += (1 << len);
                len++;
            end else begin
                err = 1;
            end
            if (mark_q[i] > 7 * U) err = 1;
            if (gap_q[i] > 3 * U) begin
                e.code = code;
                e.len  = len;
                e.err  = err;
                e.idx  = i;
                exp_sym.push_back(e);
                if (gap_q[i] > 7 * U) exp_wg.push_back(i);
                code = 0;
                len  = 0;
                err  = 0;
            end
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        KEY = lvl;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_logs();
        sym_q.delete();
        wg_q.delete();
        fall_q.delete();
        led_rises = 0;
    endtask

    task automatic run_seq(input string name);
        build_model();
        clear_logs();
        foreach (mark_q[i]) begin
            drive(1'b1, mark_q[i]);
            drive(1'b0, gap_q[i]);
        end
        chk({name, ".releases"}, fall_q.size(), mark_q.size());
        chk({name, ".nsym"}, sym_q.size(), exp_sym.size());
        for (int k = 0; k < exp_sym.size() && k < sym_q.size(); k++) begin
            chk({name, ".code"}, sym_q[k].code, exp_sym[k].code);
            chk({name, ".len"},  sym_q[k].len,  exp_sym[k].len);
            chk({name, ".err"},  sym_q[k].err,  exp_sym[k].err);
            if (exp_sym[k].idx < fall_q.size())
                chk({name, ".sym_lat"}, sym_q[k].cyc - fall_q[exp_sym[k].idx], 3 * U);
        end
        chk({name, ".nwg"}, wg_q.size(), exp_wg.size());
        for (int k = 0; k < exp_wg.size() && k < wg_q.size(); k++) begin
            if (exp_wg[k] < fall_q.size())
                chk({name, ".wg_lat"}, wg_q[k] - fall_q[exp_wg[k]], 7 * U);
        end
    endtask

    // Random durations stay clear of the unit boundaries so classification
    // is unambiguous.
    function automatic int rand_mark();
        int r = int'($urandom_range(0, 99));
        if (r < 45) return int'($urandom_range(6, 28));
        if (r < 90) return int'($urandom_range(36, 100));
        return int'($urandom_range(120, 150));
    endfunction

    task automatic build_random(input int n_letters);
        int n_el;
        mark_q.delete();
        gap_q.delete();
        for (int l = 0; l < n_letters; l++) begin
            n_el = int'($urandom_range(1, 7));
            for (int e = 0; e < n_el; e++) begin
                mark_q.push_back(rand_mark());
                if (e < n_el - 1)                gap_q.push_back(int'($urandom_range(6, 40)));
                else if (l == n_letters - 1)     gap_q.push_back(140);
                else if ($urandom_range(0, 1) == 0) gap_q.push_back(int'($urandom_range(52, 100)));
                else                             gap_q.push_back(int'($urandom_range(125, 160)));
            end
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        KEY = 1'b0;

        // Reset held with the key toggling: every output stays low.
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1 KEY = ~KEY;
            @(negedge CLK);
            chk("rst.led",  int'(LED),       0);
            chk("rst.vld",  int'(SYM_VALID), 0);
            chk("rst.code", int'(SYM_CODE),  0);
            chk("rst.len",  int'(SYM_LEN),   0);
            chk("rst.err",  int'(SYM_ERR),   0);
            chk("rst.wg",   int'(WORD_GAP),  0);
        end
        @(posedge CLK);
        #1;
        KEY = 1'b0;
        RST = 1'b0;
        clear_logs();
        drive(1'b0, 200);
        chk("idle.nsym", sym_q.size(), 0);
        chk("idle.nwg",  wg_q.size(),  0);
        chk("idle.led",  int'(LED),    0);

        // Letter A: dot then dash.
        mark_q = '{20, 40};
        gap_q  = '{20, 140};
        run_seq("letter_A");

        // Glitches shorter than the debounce window never reach the decoder.
        clear_logs();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, int'($urandom_range(1, 3)));
            drive(1'b0, 5);
        end
        drive(1'b0, 150);
        chk("glitch.led_rises", led_rises,    0);
        chk("glitch.nsym",      sym_q.size(), 0);
        chk("glitch.nwg",       wg_q.size(),  0);

        // Six dots overflow a five-element symbol.
        mark_q = '{10, 10, 10, 10, 10, 10};
        gap_q  = '{20, 20, 20, 20, 20, 140};
        run_seq("overflow");

        // E followed by silence: symbol then word gap.
        mark_q = '{10};
        gap_q  = '{140};
        run_seq("E_word");

        // New press 80 cycles after release suppresses the word gap.
        mark_q = '{10, 10};
        gap_q  = '{80, 140};
        run_seq("E_E");

        // Over-long mark.
        mark_q = '{130};
        gap_q  = '{140};
        run_seq("overlong");

        // Reset in the middle of a mark discards it.
        clear_logs();
        drive(1'b1, 10);
        @(negedge CLK);
        chk("midrst.led_before", int'(LED), 1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        KEY = 1'b0;
        drive(1'b0, 3);
        @(negedge CLK);
        chk("midrst.led_in_rst", int'(LED), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(1'b0, 150);
        chk("midrst.nsym", sym_q.size(), 0);
        chk("midrst.nwg",  wg_q.size(),  0);
        mark_q = '{10};
        gap_q  = '{140};
        run_seq("E_after_rst");

        // Randomized key sequences.
        for (int r = 0; r < 3; r++) begin
            build_random(8);
            run_seq($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
